// File: rtl/dmem_responder.sv
// Data-memory target for the core's load/store port: one request at a time,
// WAIT_CYCLES of access latency, then a held response until the initiator takes it.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_p0;
  logic [31:0] addr_p0;
  logic [3:0]  be_p0;
  logic [31:0] wdata_p0;
  logic        vld_p1;
  logic [31:0] rdata_p1;
  logic        err_p1;
  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  commit;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [3:0]            acc_be;
  logic [31:0]           acc_wdata;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_err;

  assign req_ready_o = rst_ni && (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = vld_p1;
  assign rsp_rdata_o = rdata_p1;
  assign rsp_err_o   = err_p1;

  // With zero wait states the access commits on the acceptance edge itself,
  // before the captured copy exists, so the live request is used instead.
  always_comb begin
    acc_we    = we_p0;
    acc_addr  = addr_p0;
    acc_be    = be_p0;
    acc_wdata = wdata_p0;
    if (state_q == IDLE) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i;
      acc_be    = req_be_i;
      acc_wdata = req_wdata_i;
    end
    acc_idx = acc_addr[DEPTH_LOG2+1:2];
    acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    if (state_q == IDLE) commit = accept && NO_WAIT;
    else                 commit = (state_q == WAIT) && (cnt_q == 4'd0);
  end

  // Stage p0: request capture
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_p0    <= req_we_i;
      addr_p0  <= req_addr_i;
      be_p0    <= req_be_i;
      wdata_p0 <= req_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // Stage p1: access commit and response hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      vld_p1   <= 1'b0;
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= NO_WAIT ? RESP : WAIT;
            cnt_q   <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q  <= IDLE;
            vld_p1   <= 1'b0;
            rdata_p1 <= 32'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (commit) begin
        vld_p1   <= 1'b1;
        err_p1   <= acc_err;
        rdata_p1 <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

  logic        clk;
  logic        rst_ni;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v0, rdy0, we0;
  logic [31:0] addr0, wd0;
  logic [3:0]  be0;
  logic        rv0, rr0, err0;
  logic [31:0] rd0;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(we0),
    .req_addr_i(addr0), .req_be_i(be0), .req_wdata_i(wd0),
    .rsp_valid_o(rv0), .rsp_ready_i(rr0),
    .rsp_rdata_o(rd0), .rsp_err_o(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents a request in IDLE, then drives a junk write on the request port
  // until the response appears; lat counts edges from acceptance to rsp_valid.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output int lat);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h5555_5555;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
    rst_ni = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_write_read();
    int lat;
    issue(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", rsp_err); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", rsp_rdata); end
    finish_rsp();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wr_handshake: valid %b ready %b expected 0 1", rsp_valid, req_ready); end
    issue(1'b0, 32'h10, 4'h0, 32'h0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rsp_rdata); end
    finish_rsp();
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL rd_clear: got %h expected 0", rsp_rdata); end
  endtask

  task automatic test_byte_lanes();
    int lat;
    issue(1'b1, 32'h10, 4'h2, 32'h0000_AA00, lat);
    finish_rsp();
    issue(1'b0, 32'h10, 4'hF, 32'h0, lat);
    checks++; if (rsp_rdata !== 32'hDEAD_AAEF) begin errors++; $display("FAIL lane_data: got %h expected deadaaef", rsp_rdata); end
    finish_rsp();
    issue(1'b1, 32'h10, 4'h0, 32'h1111_1111, lat);
    checks++; if (lat !== 3 || rsp_err !== 1'b0) begin errors++; $display("FAIL be0_rsp: lat %0d err %b expected 3 0", lat, rsp_err); end
    finish_rsp();
    issue(1'b0, 32'h10, 4'h0, 32'h0, lat);
    checks++; if (rsp_rdata !== 32'hDEAD_AAEF) begin errors++; $display("FAIL be0_data: got %h expected deadaaef", rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    bad = 0;
    issue(1'b0, 32'h10, 4'h0, 32'h0, lat);
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_AAEF || req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: %0d bad cycles expected 0 (last valid %b data %h ready %b)", bad, rsp_valid, rsp_rdata, req_ready); end
    finish_rsp();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid %b ready %b expected 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_errors();
    int lat;
    issue(1'b1, 32'h12, 4'hF, 32'h0000_0000, lat);
    checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || lat !== 3) begin errors++; $display("FAIL misalign_wr: err %b data %h lat %0d expected 1 0 3", rsp_err, rsp_rdata, lat); end
    finish_rsp();
    issue(1'b1, 32'h1010, 4'hF, 32'h0000_0000, lat);
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL range_wr: err %b expected 1", rsp_err); end
    finish_rsp();
    issue(1'b0, 32'h10, 4'h0, 32'h0, lat);
    checks++; if (rsp_rdata !== 32'hDEAD_AAEF || rsp_err !== 1'b0) begin errors++; $display("FAIL err_nowrite: data %h err %b expected deadaaef 0", rsp_rdata, rsp_err); end
    finish_rsp();
    issue(1'b0, 32'h1000, 4'h0, 32'h0, lat);
    checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || lat !== 3) begin errors++; $display("FAIL range_rd: err %b data %h lat %0d expected 1 0 3", rsp_err, rsp_rdata, lat); end
    finish_rsp();
    issue(1'b0, 32'hFFC, 4'h0, 32'h0, lat);
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL top_word: err %b expected 0", rsp_err); end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, lat);
    finish_rsp();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_reset: valid %b ready %b expected 0 0", rsp_valid, req_ready); end
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_release: ready %b valid %b expected 1 0", req_ready, rsp_valid); end
    issue(1'b0, 32'h20, 4'h0, 32'h0, lat);
    checks++; if (rsp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL mid_data: got %h expected cafef00d", rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int acc;
    int rsps;
    int bad;
    acc = 0; rsps = 0; bad = 0;
    rr0 = 1'b1;
    v0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; be0 = 4'hF; wd0 = 32'h0BAD_CAFE;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL w0_ready: got %b expected 1", rdy0); end
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b1 || rd0 !== 32'd0 || err0 !== 1'b0) begin errors++; $display("FAIL w0_latency: valid %b data %h err %b expected 1 0 0", rv0, rd0, err0); end
    we0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL w0_idle: valid %b ready %b expected 0 1", rv0, rdy0); end
    for (int i = 0; i < 8; i++) begin
      if (rdy0 === 1'b1) acc++;
      @(posedge clk); #1;
      if (rv0 === 1'b1) begin
        rsps++;
        if (rd0 !== 32'h0BAD_CAFE) bad++;
      end
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d expected 4", acc); end
    checks++; if (rsps !== 4 || bad !== 0) begin errors++; $display("FAIL b2b_rsps: got %0d responses %0d bad, expected 4 0", rsps, bad); end
    v0 = 1'b0;
    rr0 = 1'b0;
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; rsp_ready = 1'b0;
    v0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wd0 = '0; rr0 = 1'b0;
    rst_ni = 1'b1;
    #2;
    test_reset();
    @(posedge clk); #1;
    test_write_read();
    test_byte_lanes();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the single-cycle core's load/store path, the target end of the core's data-memory request interface. It accepts one request at a time over a valid/ready handshake and models configurable access latency. It performs byte-lane writes or full-word reads on an internal word array, then returns a response over a second valid/ready handshake. It lets the core be verified against a memory with realistic wait states and stalls.

Parameters:
DEPTH_LOG2, 10, log2 of word count (1024 words = 4 KiB).
WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..15).

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  reset, asynchronous, active-low.
req_valid_i  input  1  request present.
req_ready_o  output  1  responder can accept a request.
req_we_i  input  1  1 = write, 0 = read.
req_addr_i  input  32  byte address.
req_be_i  input  4  byte enables for writes; bit n enables wdata[8n+7:8n].
req_wdata_i  input  32  write data.
rsp_valid_o  output  1  response present.
rsp_ready_i  input  1  initiator accepts response.
rsp_rdata_o  output  32  read data; 0 for writes and errors.
rsp_err_o  output  1  address error.

Behaviour:
- Reset is asynchronous:
  - state = IDLE, wait counter = 0.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
  - req_ready_o = 0 while rst_ni is low.
  - Any captured request is discarded. A write not yet committed is never performed.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - Acceptance happens on a cycle T with req_valid_i & req_ready_o. On that edge, capture we, addr, be and wdata.
  - Next state is WAIT with counter = WAIT_CYCLES-1, or RESP directly if WAIT_CYCLES = 0.
- WAIT:
  - req_ready_o = 0.
  - Counter decrements each cycle. Move to RESP on the edge where counter = 0.
- Access commit happens on the edge entering RESP:
  - The write is applied per enabled byte, or the read word is sampled into rsp_rdata_o.
  - rsp_err_o is registered at the same time.
  - rsp_valid_o first asserts in cycle T+1+WAIT_CYCLES.
- RESP:
  - rsp_valid_o = 1 and req_ready_o = 0.
  - rsp_rdata_o and rsp_err_o are held stable until the edge with rsp_ready_i = 1.
  - On that edge: go to IDLE, clear rsp_valid_o, clear rsp_rdata_o to 0.
  - No request is accepted in the same cycle as the response handshake. Throughput is therefore one transaction per WAIT_CYCLES+2 cycles when the initiator is always ready.
- Addressing:
  - Word index = addr[DEPTH_LOG2+1:2].
  - Error if addr[1:0] != 0, or if any of addr[31:DEPTH_LOG2+2] != 0.
  - On error: no write, rsp_rdata_o = 0, rsp_err_o = 1, latency unchanged.
- Writes:
  - be = 4'b0000 is a legal no-op write and still produces a response.
  - Write responses return rdata = 0.
- Reads ignore req_be_i and return the full word.
- Input signals outside their handshake windows are ignored:
  - req_* inputs outside IDLE.
  - rsp_ready_i outside RESP.
- Request inputs need not be held after acceptance. The captured copy is used.

Test Plan:
1. WAIT_CYCLES=2. After reset, write addr 0x10, data 0xDEADBEEF, be 0xF, accepted at cycle T -> rsp_valid_o at T+3, err 0, rdata 0. Then read 0x10 -> rdata 0xDEADBEEF.
2. Byte lanes: write 0x10, be 0x2, data 0x0000AA00 -> subsequent read of 0x10 returns 0xDEADAAEF. A be=0x0 write leaves the word unchanged and still responds.
3. Backpressure: hold rsp_ready_i low for 5 cycles during a read response -> rsp_valid_o stays 1, rdata stays constant, req_ready_o stays 0. Raise rsp_ready_i -> rsp_valid_o 0 and req_ready_o 1 on the next cycle.
4. Errors:
   - Write to misaligned addr 0x12 -> err 1, rdata 0; read of 0x10 is unchanged.
   - Read of addr 0x1000 (DEPTH_LOG2=10) -> err 1, rdata 0.
5. Reset mid-operation: write 0x20 = 0x12345678 accepted at T, rst_ni pulsed low at T+1 -> rsp_valid_o 0 immediately. After release, req_ready_o is 1 and a read of 0x20 returns its prior value.
6. WAIT_CYCLES=0 build: read accepted at T -> rsp_valid_o at T+1. Back-to-back reads with rsp_ready_i tied high -> one acceptance every 2 cycles.
